fetch_ctrl: RTL and testbench

Sequencer for the fetch stage: owns the 8-bit program counter and drives the load/flush/second-byte controls of the instruction register. Fetches one byte per cycle from instruction memory and tracks one- and two-byte instructions. Arbitrates between normal fetch, hazard stalls, taken branches, HALT and a single maskable interrupt, so the IR only ever captures a valid opcode/operand byte or a NOP bubble.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 66 ++++++
 tb/tb_fetch_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage control bundle between fetch_ctrl (master) and the pipeline/IR side (slave).
//   Inputs to the controller: stall, two_byte, br_taken, br_target, halt_req, irq, irq_en.
//   Outputs from the controller: pc, ir_ld, ir_flush, sf1, irq_ack, epc, halted.
interface fetch_if;
  logic       stall;
  logic       two_byte;
  logic       br_taken;
  logic [7:0] br_target;
  logic       halt_req;
  logic       irq;
  logic       irq_en;
  logic [7:0] pc;
  logic       ir_ld;
  logic       ir_flush;
  logic       sf1;
  logic       irq_ack;
  logic [7:0] epc;
  logic       halted;
  modport master (
    input  stall, two_byte, br_taken, br_target, halt_req, irq, irq_en,
    output pc, ir_ld, ir_flush, sf1, irq_ack, epc, halted
  );
  modport slave (
    output stall, two_byte, br_taken, br_target, halt_req, irq, irq_en,
    input  pc, ir_ld, ir_flush, sf1, irq_ack, epc, halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer owning the 8-bit PC and the IR load/flush/operand controls.
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   f    : fetch_if.master bundle (hazard/branch/halt/irq inputs; pc, IR controls, irq_ack, epc, halted)
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] IRQ_VECTOR = 8'h80
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master f
);
  typedef enum logic [1:0] {FETCH, OPERAND, HALT} state_t;
  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, epc_q, epc_d;
  logic       ld, flush, ack, irq_take;
  // irq_take already excludes br_taken, so checking it first keeps branch priority intact
  always_comb begin
    irq_take = f.irq & f.irq_en & ~f.br_taken & (((state_q == FETCH) & ~f.stall) | (state_q == HALT));
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    ld       = 1'b0;
    flush    = 1'b0;
    ack      = 1'b0;
    if (irq_take) begin
      flush   = 1'b1;
      ack     = 1'b1;
      epc_d   = pc_q;
      pc_d    = IRQ_VECTOR;
      state_d = FETCH;
    end else if (state_q != HALT) begin
      if (f.br_taken) begin
        flush   = 1'b1;
        pc_d    = f.br_target;
        state_d = FETCH;
      end else if (f.halt_req) begin
        flush   = 1'b1;
        state_d = HALT;
      end else if (!f.stall) begin
        ld      = 1'b1;
        pc_d    = pc_q + 8'd1;
        state_d = (state_q == FETCH && f.two_byte) ? OPERAND : FETCH;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      epc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end
  // IR strobes are forced low while reset is held so the IR never captures during reset
  assign f.ir_ld    = ld & rst;
  assign f.ir_flush = flush & rst;
  assign f.irq_ack  = ack & rst;
  assign f.sf1      = (state_q == OPERAND);
  assign f.halted   = (state_q == HALT);
  assign f.pc       = pc_q;
  assign f.epc      = epc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed + randomized check of fetch_ctrl against a cycle-level behavioural model.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] m_pc, m_epc;
  bit         m_op, m_halt;
  fetch_if f();
  fetch_ctrl dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else passed++;
  endtask
  task automatic model_reset();
    m_pc = 8'h00; m_epc = 8'h00; m_op = 1'b0; m_halt = 1'b0;
  endtask
  // One cycle: drive inputs, check combinational strobes, advance model, check registered state after the edge.
  task automatic cyc(input bit s, input bit tb, input bit br, input logic [7:0] tg,
                     input bit h, input bit i, input bit e);
    bit take, el, ef, ea;
    f.stall = s; f.two_byte = tb; f.br_taken = br; f.br_target = tg;
    f.halt_req = h; f.irq = i; f.irq_en = e;
    #1;
    take = i & e & !br & ((!m_op & !m_halt & !s) | m_halt);
    el = 1'b0; ef = 1'b0; ea = 1'b0;
    if (take) begin
      ef = 1'b1; ea = 1'b1; m_epc = m_pc; m_pc = 8'h80; m_op = 1'b0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (br) begin
        ef = 1'b1; m_pc = tg; m_op = 1'b0;
      end else if (h) begin
        ef = 1'b1; m_halt = 1'b1; m_op = 1'b0;
      end else if (!s) begin
        el = 1'b1; m_pc = m_pc + 8'd1; m_op = !m_op & tb;
      end
    end
    chk("ir_ld", {7'd0, f.ir_ld}, {7'd0, el});
    chk("ir_flush", {7'd0, f.ir_flush}, {7'd0, ef});
    chk("irq_ack", {7'd0, f.irq_ack}, {7'd0, ea});
    @(posedge clk);
    #1;
    chk("pc", f.pc, m_pc);
    chk("sf1", {7'd0, f.sf1}, {7'd0, m_op});
    chk("halted", {7'd0, f.halted}, {7'd0, m_halt});
    chk("epc", f.epc, m_epc);
  endtask
  initial begin
    rst = 1'b0;
    f.stall = 1'b0; f.two_byte = 1'b0; f.br_taken = 1'b0; f.br_target = 8'h00;
    f.halt_req = 1'b0; f.irq = 1'b1; f.irq_en = 1'b1;
    #3;
    chk("rst_pc", f.pc, 8'h00);
    chk("rst_epc", f.epc, 8'h00);
    chk("rst_ir_ld", {7'd0, f.ir_ld}, 8'h00);
    chk("rst_ir_flush", {7'd0, f.ir_flush}, 8'h00);
    chk("rst_irq_ack", {7'd0, f.irq_ack}, 8'h00);
    chk("rst_sf1", {7'd0, f.sf1}, 8'h00);
    chk("rst_halted", {7'd0, f.halted}, 8'h00);
    #9;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 8'h00, 0, 0, 1);
    chk("run_pc5", f.pc, 8'h05);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    chk("op_pc6", f.pc, 8'h06);
    chk("op_sf1", {7'd0, f.sf1}, 8'h01);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    chk("op_back_sf1", {7'd0, f.sf1}, 8'h00);
    chk("op_back_pc", f.pc, 8'h07);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    cyc(1, 0, 0, 8'h00, 0, 0, 1);
    cyc(1, 0, 0, 8'h00, 0, 0, 1);
    chk("stall_pc", f.pc, 8'h08);
    chk("stall_sf1", {7'd0, f.sf1}, 8'h01);
    cyc(1, 0, 1, 8'h3C, 0, 0, 1);
    chk("br_pc", f.pc, 8'h3C);
    chk("br_sf1", {7'd0, f.sf1}, 8'h00);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    cyc(0, 0, 0, 8'h00, 0, 1, 1);
    chk("irq_wait_pc", f.pc, 8'h3E);
    cyc(0, 0, 0, 8'h00, 0, 1, 1);
    chk("irq_pc", f.pc, 8'h80);
    chk("irq_epc", f.epc, 8'h3E);
    cyc(0, 0, 1, 8'hFF, 0, 0, 1);
    chk("wrap_ff", f.pc, 8'hFF);
    cyc(0, 0, 0, 8'h00, 0, 0, 1);
    chk("wrap_00", f.pc, 8'h00);
    cyc(1, 0, 0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 5; k++) cyc(k[0], 1, 1, 8'h55, 1, 0, 1);
    chk("halt_pc", f.pc, 8'h00);
    chk("halt_flag", {7'd0, f.halted}, 8'h01);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 8'h00, 0, 1, 0);
    chk("halt_noen", {7'd0, f.halted}, 8'h01);
    cyc(0, 0, 0, 8'h00, 0, 1, 1);
    chk("halt_irq_pc", f.pc, 8'h80);
    chk("halt_irq_epc", f.epc, 8'h00);
    chk("halt_irq_flag", {7'd0, f.halted}, 8'h00);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    chk("pre_arst_sf1", {7'd0, f.sf1}, 8'h01);
    rst = 1'b0;
    #1;
    chk("arst_pc", f.pc, 8'h00);
    chk("arst_sf1", {7'd0, f.sf1}, 8'h00);
    chk("arst_ir_ld", {7'd0, f.ir_ld}, 8'h00);
    model_reset();
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
          8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
